irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt controller inside SOC, directly downstream of the IRQ input pads and upstream of the EOI output pads.
- Synchronises the 16 asynchronous pad interrupts and latches them as pending, either edge- or level-triggered.
- Offers the highest-priority pending line to the core over a valid/ready claim handshake, tracks the one in-service line, and drives a fixed-width EOI pulse back out on completion.

Parameters:
- NUM_IRQ, 16, number of interrupt lines (matches pad count).
- SYNC_STAGES, 2, synchroniser flop depth (legal values 2..4).
- EOI_PULSE_CYCLES, 4, width of the eoi pulse in clk cycles (legal values 1..255).

Ports:
- clk  input  1  core clock.
- rstn  input  1  asynchronous active-low reset.
- irq  input  NUM_IRQ  raw interrupts from the input pads; asynchronous to clk.
- cfg_enable  input  NUM_IRQ  per-line enable.
- cfg_edge  input  NUM_IRQ  1 = rising-edge triggered, 0 = level-high triggered.
- irq_valid  output  1  claim offer valid.
- irq_id  output  $clog2(NUM_IRQ)  offered line index.
- irq_ready  input  1  core accepts the offer (claim).
- complete_valid  input  1  core signals end of service.
- complete_id  input  $clog2(NUM_IRQ)  id being completed.
- eoi  output  NUM_IRQ  one-hot EOI pulse to the output pads.
- in_service  output  1  a line is claimed and not yet fully retired.
- err  output  1  one-cycle pulse on an illegal complete.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled externally):
  - All outputs 0; all pending bits, synchroniser flops and edge history 0; FSM in IDLE; pulse counter 0.
  - Reset mid-operation aborts any offer, service or EOI pulse immediately; eoi drops to 0 asynchronously.
- Sync: each irq bit passes through SYNC_STAGES flops, giving s. prev holds s delayed by one cycle.
- Pending (edge mode, cfg_edge[i]=1):
  - Set when s[i] & ~prev[i] & cfg_enable[i].
  - Cleared on the claim handshake of line i.
  - Cleared when cfg_enable[i]=0.
  - If a set and the claim clear hit the same cycle, set wins and the bit stays 1.
- Pending (level mode, cfg_edge[i]=0):
  - pending[i] = s[i] & cfg_enable[i], combinational from registered s; no latching.
- Eligibility and priority:
  - eligible = pending & ~mask. mask is the one-hot of the active line while the FSM is in OFFER, SERVICE or EOI; otherwise 0.
  - Priority is fixed, lowest index wins.
- FSM IDLE:
  - If eligible != 0, register the winning id into irq_id and go to OFFER.
  - Latency: irq_valid rises SYNC_STAGES+2 cycles after the first clk edge that samples irq high.
- FSM OFFER:
  - irq_valid=1; irq_id held stable until the handshake, even if the source drops or another line wins priority.
  - On irq_valid & irq_ready, go to SERVICE and set in_service=1 in the next cycle.
- FSM SERVICE:
  - Wait for complete_valid.
  - If complete_id == active id: load the counter with EOI_PULSE_CYCLES and go to EOI.
  - If complete_id differs: err pulses for 1 cycle and the FSM stays in SERVICE.
  - complete_valid in IDLE or OFFER: err pulses and the input is ignored.
- FSM EOI:
  - eoi = one-hot(active id), registered, for exactly EOI_PULSE_CYCLES cycles; the counter decrements each cycle.
  - Go to IDLE when the counter reaches 1.
  - in_service stays 1 through EOI and clears on entry to IDLE.
- Re-offer: a level line still high after IDLE is re-offered with the normal IDLE->OFFER latency of 1 cycle. Only one line is in service at any time; no nesting or pre-emption.
- Width rule: irq_id and complete_id are compared at full $clog2(NUM_IRQ) width. For non-power-of-2 NUM_IRQ, a complete_id >= NUM_IRQ is treated as a mismatch.

Decomposition:
- irq_pkg holds:
  - NUM_IRQ_DEF = 16.
  - IRQ_ID_W = $clog2(NUM_IRQ_DEF).
  - typedef irq_id_t.
  - typedef enum logic [1:0] irq_state_e: IDLE, OFFER, SERVICE, EOI.
- Sub-module irq_sync: parameterised N-stage multi-bit synchroniser with async active-low reset, instantiated once at width NUM_IRQ.

Test Plan:
- Edge line: cfg_edge=16'hFFFF, enable all; pulse irq[5] high for 3 cycles -> irq_valid=1 with irq_id=5 exactly 4 cycles after the first sampling edge; claim; complete_id=5 -> eoi=16'h0020 for 4 cycles; in_service then falls to 0.
- Priority/stability: irq[9] asserted, and irq[2] asserted while id 9 is being offered (irq_ready held 0) -> irq_id stays 9 until the handshake. After 9 is completed, id 2 is offered next.
- Level re-offer: cfg_edge[3]=0, irq[3] held high -> claim 3, complete 3, 4-cycle eoi, then irq_valid re-asserts with id 3 one cycle after IDLE.
- Wrong complete: line 7 in service, complete_id=6 -> err=1 for one cycle, eoi=0, state unchanged. A following complete_id=7 retires line 7 normally.
- Edge during claim: edge on irq[4] lands on the same cycle as the claim of id 4 -> pending[4] remains 1, and id 4 is re-offered after its EOI completes.
- Reset mid-EOI: rstn=0 during cycle 2 of the eoi pulse -> eoi, irq_valid, in_service and err all 0 immediately. After release, no offer occurs until a new edge arrives.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt controller.
//   NUM_IRQ_DEF : default number of interrupt lines (pad count)
//   IRQ_ID_W    : width of a line index at the default line count
//   irq_id_t    : line index type at the default line count
//   irq_state_e : claim/service FSM states
package irq_pkg;

    localparam int unsigned NUM_IRQ_DEF = 16;
    localparam int unsigned IRQ_ID_W    = $clog2(NUM_IRQ_DEF);

    typedef logic [IRQ_ID_W-1:0] irq_id_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        SERVICE = 2'd2,
        EOI     = 2'd3
    } irq_state_e;

endpackage

// File: rtl/irq_sync.sv
// Multi-bit N-stage synchroniser for asynchronous level inputs.
// Each bit is treated independently; no cross-bit coherency is implied.
//   clk    : destination clock
//   rstn   : asynchronous active-low reset, clears every stage
//   data_i : asynchronous input bits
//   data_o : synchronised bits (output of the last stage)
module irq_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises pad interrupts, latches them as pending
// (edge or level), offers the lowest-index pending line to the core over a
// valid/ready claim, tracks the single in-service line and emits a fixed-width
// one-hot EOI pulse when the core completes it.
//   clk, rstn      : core clock, asynchronous active-low reset
//   irq            : raw pad interrupts (asynchronous)
//   cfg_enable     : per-line enable
//   cfg_edge       : per-line mode, 1 = rising edge, 0 = level high
//   irq_valid      : claim offer valid
//   irq_id         : offered (and afterwards active) line index
//   irq_ready      : core accepts the offer
//   complete_valid : core signals end of service
//   complete_id    : line being completed
//   eoi            : one-hot EOI pulse to the output pads
//   in_service     : a line is claimed and not yet fully retired
//   err            : one-cycle pulse on an illegal complete
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ          = NUM_IRQ_DEF,
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned EOI_PULSE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_IRQ-1:0]         irq,
    input  logic [NUM_IRQ-1:0]         cfg_enable,
    input  logic [NUM_IRQ-1:0]         cfg_edge,
    output logic                       irq_valid,
    output logic [$clog2(NUM_IRQ)-1:0] irq_id,
    input  logic                       irq_ready,
    input  logic                       complete_valid,
    input  logic [$clog2(NUM_IRQ)-1:0] complete_id,
    output logic [NUM_IRQ-1:0]         eoi,
    output logic                       in_service,
    output logic                       err
);

    localparam int unsigned ID_W  = $clog2(NUM_IRQ);
    localparam int unsigned CNT_W = 8;

    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pend_d;
    logic [NUM_IRQ-1:0] edge_set;
    logic [NUM_IRQ-1:0] claim_clr;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] active_oh;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] eligible;
    logic [ID_W-1:0]    win_id;
    logic               win_any;
    logic               claim;

    irq_state_e         state_q;
    logic [ID_W-1:0]    irq_id_q;
    logic               irq_valid_q;
    logic               in_service_q;
    logic [NUM_IRQ-1:0] eoi_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;

    irq_sync #(
        .WIDTH  (NUM_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rstn   (rstn),
        .data_i (irq),
        .data_o (s)
    );

    assign claim     = (state_q == OFFER) && irq_ready;
    assign active_oh = NUM_IRQ'(1) << irq_id_q;
    assign mask      = (state_q != IDLE) ? active_oh : '0;

    // Edge-mode latch. Set is OR-ed in after the claim clear so a new edge
    // arriving on the claim cycle is not lost. Level lines keep this register
    // at zero so a later mode switch cannot expose stale state.
    always_comb begin
        edge_set  = s & ~prev_q & cfg_enable;
        claim_clr = '0;
        if (claim) begin
            claim_clr = active_oh;
        end
        pend_d = ((pend_q & ~claim_clr) | edge_set) & cfg_enable & cfg_edge;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_q <= '0;
            pend_q <= '0;
        end else begin
            prev_q <= s;
            pend_q <= pend_d;
        end
    end

    // Level lines follow the synchronised input directly.
    assign pending  = (pend_q & cfg_edge) | (s & cfg_enable & ~cfg_edge);
    assign eligible = pending & ~mask;

    // Fixed priority: scan downwards so the lowest set index wins.
    always_comb begin
        win_any = |eligible;
        win_id  = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            irq_id_q     <= '0;
            irq_valid_q  <= 1'b0;
            in_service_q <= 1'b0;
            eoi_q        <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (complete_valid) begin
                        err_q <= 1'b1;
                    end
                    if (win_any) begin
                        irq_id_q    <= win_id;
                        irq_valid_q <= 1'b1;
                        state_q     <= OFFER;
                    end
                end
                OFFER: begin
                    if (complete_valid) begin
                        err_q <= 1'b1;
                    end
                    // irq_id_q is frozen here regardless of pending changes.
                    if (irq_ready) begin
                        irq_valid_q  <= 1'b0;
                        in_service_q <= 1'b1;
                        state_q      <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (complete_valid) begin
                        // Full-width compare: ids >= NUM_IRQ never match.
                        if (complete_id == irq_id_q) begin
                            cnt_q   <= CNT_W'(EOI_PULSE_CYCLES);
                            eoi_q   <= active_oh;
                            state_q <= EOI;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                EOI: begin
                    if (cnt_q == CNT_W'(1)) begin
                        eoi_q        <= '0;
                        in_service_q <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign irq_valid  = irq_valid_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;
    assign eoi        = eoi_q;
    assign err        = err_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus a randomized phase, all outputs
// compared every cycle against a behavioural model of the controller.
module tb_irq_ctrl;

    localparam int unsigned N = 16;
    localparam int unsigned S = 2;
    localparam int unsigned P = 4;
    localparam int unsigned W = $clog2(N);

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic [N-1:0] irq = '0;
    logic [N-1:0] cfg_enable = '1;
    logic [N-1:0] cfg_edge = '1;
    logic         irq_valid;
    logic [W-1:0] irq_id;
    logic         irq_ready = 1'b0;
    logic         complete_valid = 1'b0;
    logic [W-1:0] complete_id = '0;
    logic [N-1:0] eoi;
    logic         in_service;
    logic         err;

    always #5 clk = ~clk;

    irq_ctrl #(
        .NUM_IRQ          (N),
        .SYNC_STAGES      (S),
        .EOI_PULSE_CYCLES (P)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .irq            (irq),
        .cfg_enable     (cfg_enable),
        .cfg_edge       (cfg_edge),
        .irq_valid      (irq_valid),
        .irq_id         (irq_id),
        .irq_ready      (irq_ready),
        .complete_valid (complete_valid),
        .complete_id    (complete_id),
        .eoi            (eoi),
        .in_service     (in_service),
        .err            (err)
    );

    int checks = 0;
    int errors = 0;

    // Model: raw samples awaiting synchronisation, per-line latched edges,
    // and the controller's situation as plain facts about the active line.
    logic [N-1:0] m_samp[$];
    logic [N-1:0] m_prev;
    logic [N-1:0] m_pend;
    int           m_active;
    bit           m_offer;
    bit           m_served;
    int           m_eoi_left;
    bit           m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_samp.delete();
        for (int i = 0; i < int'(S); i++) m_samp.push_back('0);
        m_prev     = '0;
        m_pend     = '0;
        m_active   = -1;
        m_offer    = 0;
        m_served   = 0;
        m_eoi_left = 0;
        m_err      = 0;
    endtask

    // Advance the model using the inputs visible before the edge, clock the
    // DUT, then compare every output just after the edge.
    task automatic tick();
        logic [N-1:0] s, pending, set, clr;
        int           win;
        bit           err_n;
        s       = m_samp[S-1];
        pending = (m_pend & cfg_edge) | (s & cfg_enable & ~cfg_edge);
        set     = s & ~m_prev & cfg_enable;
        clr     = '0;
        err_n   = 0;
        win     = -1;
        for (int i = int'(N) - 1; i >= 0; i--) if (pending[i]) win = i;
        if (m_eoi_left > 0) begin
            m_eoi_left--;
            if (m_eoi_left == 0) begin
                m_served = 0;
                m_active = -1;
            end
        end else if (m_served) begin
            if (complete_valid) begin
                if (int'(complete_id) == m_active) m_eoi_left = P;
                else err_n = 1;
            end
        end else if (m_offer) begin
            err_n = complete_valid;
            if (irq_ready) begin
                m_offer  = 0;
                m_served = 1;
                clr[m_active] = 1'b1;
            end
        end else begin
            err_n = complete_valid;
            if (win >= 0) begin
                m_active = win;
                m_offer  = 1;
            end
        end
        m_err  = err_n;
        m_pend = ((m_pend & ~clr) | set) & cfg_enable;
        m_prev = s;
        m_samp.push_front(irq);
        void'(m_samp.pop_back());

        @(posedge clk);
        #1;
        check("valid", 32'(irq_valid), 32'(m_offer));
        if (m_offer) check("id", 32'(irq_id), 32'(m_active));
        check("in_service", 32'(in_service), 32'(m_served));
        check("eoi", 32'(eoi), (m_eoi_left > 0) ? (32'd1 << m_active) : 32'd0);
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!irq_valid && n < limit) begin
            tick();
            n++;
        end
        check("wait_valid", 32'(irq_valid), 32'd1);
    endtask

    // Claim the current offer, complete it correctly, and run out the EOI.
    task automatic serve(input int id);
        irq_ready = 1'b1;
        tick();
        irq_ready      = 1'b0;
        complete_valid = 1'b1;
        complete_id    = W'(id);
        tick();
        complete_valid = 1'b0;
        repeat (P) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        model_reset();
        #1;
        rstn = 1'b0;
        #1;
        check("rst_valid", 32'(irq_valid), 32'd0);
        check("rst_eoi", 32'(eoi), 32'd0);
        check("rst_insvc", 32'(in_service), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Edge line 5: 3-cycle pulse, latency, claim, 4-cycle EOI.
        irq[5] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 3) irq[5] = 1'b0;
        end while (!irq_valid && n < 20);
        check("t1_latency", 32'(n), 32'(S + 2));
        check("t1_id", 32'(irq_id), 32'd5);
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        check("t1_insvc", 32'(in_service), 32'd1);
        complete_valid = 1'b1;
        complete_id    = W'(5);
        tick();
        complete_valid = 1'b0;
        n = 0;
        while (eoi == 16'h0020 && n < 20) begin
            n++;
            tick();
        end
        check("t1_eoi_len", 32'(n), 32'(P));
        check("t1_insvc_end", 32'(in_service), 32'd0);

        // Priority/stability: 2 arrives while 9 is offered.
        irq[9] = 1'b1;
        wait_valid(20, n);
        irq[9] = 1'b0;
        check("t2_id9", 32'(irq_id), 32'd9);
        irq[2] = 1'b1;
        repeat (6) tick();
        check("t2_hold9", 32'(irq_id), 32'd9);
        irq[2] = 1'b0;
        serve(9);
        wait_valid(20, n);
        check("t2_next_id2", 32'(irq_id), 32'd2);
        serve(2);

        // Level line 3 held high: re-offered one cycle after returning idle.
        cfg_edge[3] = 1'b0;
        irq[3] = 1'b1;
        wait_valid(20, n);
        check("t3_id3", 32'(irq_id), 32'd3);
        serve(3);
        wait_valid(20, n);
        check("t3_reoffer_lat", 32'(n), 32'd1);
        check("t3_reoffer_id", 32'(irq_id), 32'd3);
        irq[3] = 1'b0;
        serve(3);
        do_reset();
        cfg_edge = '1;

        // Wrong complete while 7 is in service.
        irq[7] = 1'b1;
        wait_valid(20, n);
        irq[7] = 1'b0;
        irq_ready = 1'b1;
        tick();
        irq_ready      = 1'b0;
        complete_valid = 1'b1;
        complete_id    = W'(6);
        tick();
        complete_valid = 1'b0;
        check("t4_err", 32'(err), 32'd1);
        check("t4_eoi", 32'(eoi), 32'd0);
        tick();
        check("t4_err_pulse", 32'(err), 32'd0);
        check("t4_insvc", 32'(in_service), 32'd1);
        complete_valid = 1'b1;
        complete_id    = W'(7);
        tick();
        complete_valid = 1'b0;
        check("t4_eoi7", 32'(eoi), 32'h0080);
        repeat (P) tick();

        // New edge on 4 lands on the claim cycle of 4.
        irq[4] = 1'b1;
        wait_valid(20, n);
        check("t5_id4", 32'(irq_id), 32'd4);
        irq[4] = 1'b0;
        repeat (4) tick();
        irq[4] = 1'b1;
        tick();
        tick();
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        irq[4]    = 1'b0;
        check("t5_insvc", 32'(in_service), 32'd1);
        complete_valid = 1'b1;
        complete_id    = W'(4);
        tick();
        complete_valid = 1'b0;
        repeat (P) tick();
        wait_valid(20, n);
        check("t5_reoffer_lat", 32'(n), 32'd1);
        check("t5_reoffer_id", 32'(irq_id), 32'd4);
        serve(4);

        // Reset during the second EOI cycle.
        irq[1] = 1'b1;
        wait_valid(20, n);
        irq[1] = 1'b0;
        irq_ready = 1'b1;
        tick();
        irq_ready      = 1'b0;
        complete_valid = 1'b1;
        complete_id    = W'(1);
        tick();
        complete_valid = 1'b0;
        tick();
        check("t6_eoi_pre", 32'(eoi), 32'h0002);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_eoi", 32'(eoi), 32'd0);
        check("t6_valid", 32'(irq_valid), 32'd0);
        check("t6_insvc", 32'(in_service), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        repeat (10) tick();
        check("t6_no_offer", 32'(irq_valid), 32'd0);
        irq[1] = 1'b1;
        wait_valid(20, n);
        irq[1] = 1'b0;
        check("t6_new_id", 32'(irq_id), 32'd1);
        serve(1);

        // Randomized traffic with a random but fixed mode map.
        cfg_edge = N'($urandom);
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            irq = irq ^ N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) cfg_enable = N'($urandom | $urandom);
            irq_ready      = ($urandom_range(0, 2) == 0);
            complete_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0 && m_active >= 0) complete_id = W'(m_active);
            else complete_id = W'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
